// File: rtl/text_ram_arbiter_if.sv
// Bus bundle between the text RAM arbiter, its two requesters (display, edit) and the text RAM port.
interface text_ram_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 1280
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_ack;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_rdata;

    logic              edit_req;
    logic              edit_wren;
    logic [ADDR_W-1:0] edit_addr;
    logic [DATA_W-1:0] edit_wdata;
    logic              edit_ack;
    logic              edit_valid;
    logic [DATA_W-1:0] edit_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              busy;

    // Arbiter side.
    modport slave (
        input  disp_req, disp_addr, edit_req, edit_wren, edit_addr, edit_wdata, ram_rdata,
        output disp_ack, disp_valid, disp_rdata, edit_ack, edit_valid, edit_rdata,
               ram_addr, ram_wren, ram_wdata, busy
    );

    // Requester / RAM side.
    modport master (
        output disp_req, disp_addr, edit_req, edit_wren, edit_addr, edit_wdata, ram_rdata,
        input  disp_ack, disp_valid, disp_rdata, edit_ack, edit_valid, edit_rdata,
               ram_addr, ram_wren, ram_wdata, busy
    );
endinterface

// File: rtl/text_ram_arbiter.sv
// Single-port text RAM arbiter: display-priority grant with an edit starvation guard,
// registered RAM port and owner-tagged read return pipeline.
module text_ram_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 1280,
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    text_ram_arbiter_if.slave  bus_io
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_DISP,
        GRANT_EDIT
    } grant_e;

    grant_e            grant;
    logic [CNT_W-1:0]  starve_q, starve_d;

    logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
    logic              ramWren_q, ramWren_d;
    logic [DATA_W-1:0] ramWdata_q, ramWdata_d;

    logic                  issueRead;
    logic                  issueEdit;
    logic [READ_LATENCY:0] tagValid_q, tagValid_d;
    logic [READ_LATENCY:0] tagEdit_q, tagEdit_d;

    logic              dispValid_q, dispValid_d;
    logic [DATA_W-1:0] dispRdata_q, dispRdata_d;
    logic              editValid_q, editValid_d;
    logic [DATA_W-1:0] editRdata_q, editRdata_d;

    // Acks are suppressed while reset is held so nothing is consumed that will not issue.
    always_comb begin
        grant = GRANT_NONE;
        if (rst_ni) begin
            if (bus_io.edit_req && (!bus_io.disp_req || starve_q == LIMIT)) begin
                grant = GRANT_EDIT;
            end else if (bus_io.disp_req) begin
                grant = GRANT_DISP;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus_io.edit_req || grant == GRANT_EDIT) begin
            starve_d = '0;
        end else if (grant == GRANT_DISP && starve_q != LIMIT) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_comb begin
        ramAddr_d  = ramAddr_q;
        ramWren_d  = 1'b0;
        ramWdata_d = ramWdata_q;
        issueRead  = 1'b0;
        issueEdit  = 1'b0;
        case (grant)
            GRANT_DISP: begin
                ramAddr_d = bus_io.disp_addr;
                issueRead = 1'b1;
            end
            GRANT_EDIT: begin
                ramAddr_d  = bus_io.edit_addr;
                ramWren_d  = bus_io.edit_wren;
                ramWdata_d = bus_io.edit_wdata;
                issueRead  = !bus_io.edit_wren;
                issueEdit  = 1'b1;
            end
            default: ;
        endcase
    end

    // Stage k of the tag pipe lines up with the read whose address was presented k cycles ago.
    always_comb begin
        tagValid_d  = {tagValid_q[READ_LATENCY-1:0], issueRead};
        tagEdit_d   = {tagEdit_q[READ_LATENCY-1:0], issueEdit};
        dispValid_d = tagValid_q[READ_LATENCY] && !tagEdit_q[READ_LATENCY];
        editValid_d = tagValid_q[READ_LATENCY] &&  tagEdit_q[READ_LATENCY];
        dispRdata_d = dispValid_d ? bus_io.ram_rdata : dispRdata_q;
        editRdata_d = editValid_d ? bus_io.ram_rdata : editRdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            starve_q    <= '0;
            ramAddr_q   <= '0;
            ramWren_q   <= 1'b0;
            ramWdata_q  <= '0;
            tagValid_q  <= '0;
            tagEdit_q   <= '0;
            dispValid_q <= 1'b0;
            dispRdata_q <= '0;
            editValid_q <= 1'b0;
            editRdata_q <= '0;
        end else begin
            starve_q    <= starve_d;
            ramAddr_q   <= ramAddr_d;
            ramWren_q   <= ramWren_d;
            ramWdata_q  <= ramWdata_d;
            tagValid_q  <= tagValid_d;
            tagEdit_q   <= tagEdit_d;
            dispValid_q <= dispValid_d;
            dispRdata_q <= dispRdata_d;
            editValid_q <= editValid_d;
            editRdata_q <= editRdata_d;
        end
    end

    assign bus_io.disp_ack   = (grant == GRANT_DISP);
    assign bus_io.edit_ack   = (grant == GRANT_EDIT);
    assign bus_io.disp_valid = dispValid_q;
    assign bus_io.disp_rdata = dispRdata_q;
    assign bus_io.edit_valid = editValid_q;
    assign bus_io.edit_rdata = editRdata_q;
    assign bus_io.ram_addr   = ramAddr_q;
    assign bus_io.ram_wren   = ramWren_q;
    assign bus_io.ram_wdata  = ramWdata_q;
    assign bus_io.busy       = |tagValid_q;
endmodule

// File: doc/text_ram_arbiter.md
Name: text_ram_arbiter

Overview:
- Shares the single-port text RAM between two requesters: the terminal text-edit path (row read-modify-write from the command dispatcher) and the display scan-out reader.
- Arbitrates one access per cycle with display priority and a starvation guard for the edit path.
- Registers the RAM port and tags in-flight reads so each read result returns only to its owner.
- Sits between the parser/text-edit logic, the renderer and the text RAM instance.

Parameters:
- ADDR_W, 5: row address width (one RAM word per console row).
- DATA_W, 1280: row word width (80 columns x 16 bits).
- READ_LATENCY, 2: cycles from ram_addr presentation to valid ram_rdata (1..4).
- STARVE_LIMIT, 4: consecutive contended edit losses before the edit path is forced to win.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- disp_req  in  1  display read request; held until disp_ack
- disp_addr  in  ADDR_W  display row address
- disp_ack  out  1  display request accepted this cycle
- disp_valid  out  1  display read data valid, one-cycle pulse
- disp_rdata  out  DATA_W  display read data
- edit_req  in  1  edit request; held with fields stable until edit_ack
- edit_wren  in  1  1 = write, 0 = read
- edit_addr  in  ADDR_W  edit row address
- edit_wdata  in  DATA_W  edit write data
- edit_ack  out  1  edit request accepted this cycle
- edit_valid  out  1  edit read data valid, one-cycle pulse
- edit_rdata  out  DATA_W  edit read data
- ram_addr  out  ADDR_W  RAM address, registered
- ram_wren  out  1  RAM write enable, registered
- ram_wdata  out  DATA_W  RAM write data, registered
- ram_rdata  in  DATA_W  RAM read data
- busy  out  1  at least one read in flight

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0, starve counter 0, pipeline tags cleared.
  - Reads in flight at reset are dropped: no valid pulse appears after reset.
- Arbitration is decided combinationally in cycle t from the *_req inputs.
  - Exactly one of disp_ack/edit_ack is high if any request is present; both are low if none.
  - The ack marks consumption; the requester may change its fields in t+1.
- Priority:
  - Display wins, unless edit_req=1 and starve_cnt==STARVE_LIMIT; then edit wins.
  - Only one requester present: that requester wins.
- Starve counter (width clog2(STARVE_LIMIT+1)):
  - Increments when both requests are present and display wins.
  - Clears when edit wins or edit_req=0.
  - Saturates at STARVE_LIMIT.
- Issue: at the edge ending cycle t, ram_addr, ram_wren and ram_wdata load from the winner.
  - The display winner always issues ram_wren=0.
  - No winner: ram_wren <= 0; ram_addr and ram_wdata hold their previous values.
- Read return: a read issued (ram_addr presented) in cycle t+1 has valid ram_rdata in cycle t+1+READ_LATENCY.
  - In that cycle the arbiter registers it to the owner: xxx_valid=1 and xxx_rdata=data in cycle t+2+READ_LATENCY.
  - Total request-to-valid latency is READ_LATENCY+2 cycles, fixed.
- Owner tags travel in a READ_LATENCY+1 deep shift register (2 bits: valid, owner). Writes insert no tag.
- Back-to-back reads are fully pipelined at one per cycle, and results return in issue order.
- rdata outputs hold their last value when valid=0.
- Ordering: no forwarding is performed. An edit write followed by an edit read of the same row returns the new data because of issue order.
  - A display read issued before an edit write returns the old data.
- busy = OR of tag valid bits.

Test Plan:
- Reset then idle: all outputs 0 for 10 cycles, ram_wren=0.
- Edit read-modify-write of row 3 with RAM preloaded to 0xAA..:
  - edit_ack in cycle 0; edit_valid in cycle 4 with rdata 0xAA.. (READ_LATENCY=2).
  - Write 0x55.. acked next cycle.
  - Display read of row 3 then returns 0x55..
- Continuous disp_req and edit_req for 20 cycles: edit_ack exactly in cycles 4, 9, 14, 19. Display acks in all other cycles.
- Display reads of rows 0..7 back-to-back: 8 disp_valid pulses on consecutive cycles 4..11, in row order, with no edit_valid pulses.
- Assert rst=0 one cycle after a read issue: no disp_valid afterwards, busy=0 the cycle after reset, counter cleared.
- Simultaneous display read of row 2 and edit write of row 2 (counter 0):
  - Display acked first and returns the old data.
  - Edit acked in the next cycle; a subsequent read returns the new data.
